lcd_sequencer: RTL and testbench
================================

# lcd_sequencer

Drives the board's HD44780-class character LCD. After reset it runs the power-on init command sequence and then writes the 16-character line-1 banner, one character per bus step, pulling each character from the combinational mode-text lookup through `char_idx`/`char_data`. It sits between the mode FSM (source of `mode`) and the LCD pins. It repaints line 1 whenever the selected mode changes.

## Interface
- `STEP_CYCLES`, 2000: clk cycles per LCD bus step. At 1 MHz clk this is 2 ms, which covers the clear-display execution time. Must be ≥ 8.
- `POR_STEPS`, 20: idle steps after reset before the first command (40 ms at the default setting).
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `mode`  in  2: requested mode; 00 WATCH, 01 ALARM, 10 STOPWATCH.
- `char_data`  in  8: ASCII from the text lookup for (`disp_mode`, `char_idx`).
- `disp_mode`  out  2: mode currently being painted; drives the lookup.
- `char_idx`  out  4: character position 0–15; drives the lookup.
- `lcd_e`  out  1: LCD enable strobe.
- `lcd_rs`  out  1: 0 = command, 1 = data.
- `lcd_rw`  out  1: tied 0 (write only).
- `lcd_data`  out  8: LCD bus.
- `busy`  out  1: high while any init or paint pass is in progress.

## Operation
- Reset values: `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=8'h00, `char_idx`=0, `disp_mode`=2'b00, `busy`=1, state=POR.
- State sequence, one bus step each unless noted:
  - POR: `POR_STEPS` steps, `lcd_e` held low.
  - FSET: 8'h38.
  - DISP: 8'h0C.
  - ENTRY: 8'h06.
  - CLEAR: 8'h01.
  - ADDR: 8'h80.
  - CHAR ×16.
  - IDLE.
- All states except CHAR have `lcd_rs`=0. CHAR has `lcd_rs`=1.
- `disp_mode` is loaded from `mode` on entry to ADDR. It holds constant for the whole pass, so a pass never mixes text from two modes.
- CHAR: `char_idx` is stable for the entire step. `lcd_data` is loaded from `char_data` on step tick 0. `char_idx` increments on the last tick of the step. After index 15, `char_idx` wraps to 0 and the FSM enters IDLE.
- IDLE: `busy`=0. If `mode` ≠ `disp_mode`, go to ADDR on the next cycle (repaint, 17 steps).
- A mode change during FSET..CHAR does not abort the pass. The pass completes, then IDLE sees the mismatch and repaints. Several changes during one pass cause exactly one repaint, using the `mode` value sampled at the next ADDR entry.
- `mode` = 2'b11 is treated as a normal mode value; the lookup returns blanks for it.
- Asserting `rst` at any point restores all reset values immediately and restarts from POR, including a full re-init.

## Timing
- Step timer `tick` counts 0..`STEP_CYCLES`-1 and restarts at each step.
- `lcd_e`=1 exactly for `tick` in [`STEP_CYCLES`/4, 3·`STEP_CYCLES`/4). `lcd_e` is otherwise 0.
- `lcd_rs` and `lcd_data` change only at `tick`=0 (or the cycle after, for CHAR data). They are therefore stable at least `STEP_CYCLES`/4−1 cycles before the `lcd_e` rise and `STEP_CYCLES`/4 cycles after the `lcd_e` fall.
- First pass length from reset release: (`POR_STEPS`+21)·`STEP_CYCLES` cycles. `busy` falls on the following cycle.
- Repaint: `busy` rises one cycle after the IDLE mismatch is detected. Latency from detection to `busy` falling is 17·`STEP_CYCLES`+1 cycles.
- All outputs are registered; no combinational path from `mode` or `char_data` to any pin.

## Structure
- Shared package `lcd_pkg`:
  - LCD command constants (`CMD_FSET`, `CMD_DISP_ON`, `CMD_ENTRY`, `CMD_CLEAR`, `CMD_LINE1`).
  - State enum.
  - Mode codes WATCH/ALARM/STOPWATCH, shared with the mode FSM and the text lookup.
- Sub-module `lcd_step_timer`: parameterised by `STEP_CYCLES`. Outputs `step_start`, `step_end`, and the `lcd_e` window. Reset/restart input is driven by the FSM.
- The text lookup stays external, connected through `disp_mode`/`char_idx`/`char_data`.

## Test plan
All scenarios use `STEP_CYCLES`=8 and `POR_STEPS`=2.

1. Release `rst`, `mode`=00 → `lcd_e` pulses carry 38, 0C, 06, 01, 80 with `rs`=0, then 16 pulses with `rs`=1 whose data matches "MODE1: WATCH" padded with blanks. `busy` falls at cycle 184+1.
2. Idle in WATCH, set `mode`=01 → `busy` rises the next cycle, then 80 followed by the "MODE2: ALARM" bytes. No re-init commands appear. `disp_mode`=01 throughout.
3. During CHAR index 5 of the first pass, set `mode`=10 and then 01 → the first pass finishes as WATCH, followed by exactly one repaint with `disp_mode`=01.
4. Check every pulse → `lcd_e` is high for exactly 4 cycles per step, and `rs`/`data` never change while `lcd_e`=1 or within 1 cycle of its edges.
5. Assert `rst` mid-CHAR → outputs return to reset values in the same cycle. After release, a full POR/init sequence repeats.
6. Set `mode`=11 → the repaint completes with `disp_mode`=11 and 16 blank (8'h20) data writes, then IDLE.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD sequencer, the mode FSM and the text lookup.
// Holds the HD44780 command bytes, the mode codes and the sequencer state type.
package lcd_pkg;

    localparam logic [7:0] CMD_FSET    = 8'h38;
    localparam logic [7:0] CMD_DISP_ON = 8'h0C;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_LINE1   = 8'h80;

    localparam logic [1:0] MODE_WATCH     = 2'b00;
    localparam logic [1:0] MODE_ALARM     = 2'b01;
    localparam logic [1:0] MODE_STOPWATCH = 2'b10;

    localparam int LINE_CHARS = 16;

    typedef enum logic [2:0] {
        ST_POR,
        ST_FSET,
        ST_DISP,
        ST_ENTRY,
        ST_CLEAR,
        ST_ADDR,
        ST_CHAR,
        ST_IDLE
    } lcd_state_t;

    function automatic logic [7:0] state_cmd(input lcd_state_t st);
        logic [7:0] cmd;
        cmd = 8'h00;
        case (st)
            ST_FSET:  cmd = CMD_FSET;
            ST_DISP:  cmd = CMD_DISP_ON;
            ST_ENTRY: cmd = CMD_ENTRY;
            ST_CLEAR: cmd = CMD_CLEAR;
            ST_ADDR:  cmd = CMD_LINE1;
            default:  cmd = 8'h00;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_step_timer.sv
// Bus-step timer: a down-counter that reloads every STEP_CYCLES clocks, plus the
// registered enable strobe that sits in the middle half of each step.
module lcd_step_timer #(
    parameter int STEP_CYCLES = 2000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic e_en,
    output logic step_start,
    output logic step_end,
    output logic lcd_e
);

    localparam int CW = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] CNT_TOP = CW'(STEP_CYCLES - 1);
    // Counter values at tick STEP_CYCLES/4 and tick 3*STEP_CYCLES/4-1.
    localparam logic [CW-1:0] E_HI = CW'(STEP_CYCLES - 1 - STEP_CYCLES / 4);
    localparam logic [CW-1:0] E_LO = CW'(STEP_CYCLES - (3 * STEP_CYCLES) / 4);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt - CW'(1);
        if (restart || cnt == '0) begin
            cnt_next = CNT_TOP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= CNT_TOP;
            lcd_e <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            lcd_e <= e_en && (cnt_next <= E_HI) && (cnt_next >= E_LO);
        end
    end

    assign step_start = (cnt == CNT_TOP);
    assign step_end   = (cnt == '0);

endmodule

// File: rtl/lcd_sequencer.sv
// Power-on init and line-1 banner painter for the HD44780-class LCD; repaints
// line 1 whenever the requested mode differs from the one last painted.
//
// state | meaning
// POR   | power-on wait, POR_STEPS idle steps, enable held low
// FSET  | function set command
// DISP  | display on, cursor off
// ENTRY | entry mode, auto-increment
// CLEAR | clear display
// ADDR  | set DDRAM address to line 1; latches disp_mode
// CHAR  | one data write per step, 16 steps
// IDLE  | not busy; watches for a mode change
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int STEP_CYCLES = 2000,
    parameter int POR_STEPS   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic [7:0] char_data,
    output logic [1:0] disp_mode,
    output logic [3:0] char_idx,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       busy
);

    localparam int PW = (POR_STEPS > 1) ? $clog2(POR_STEPS) : 1;
    localparam logic [3:0] LAST_IDX = 4'(LINE_CHARS - 1);

    lcd_state_t state;
    lcd_state_t state_next;
    logic [PW-1:0] por_cnt;
    logic step_start;
    logic step_end;
    logic restart;
    logic e_en;

    lcd_step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart),
        .e_en      (e_en),
        .step_start(step_start),
        .step_end  (step_end),
        .lcd_e     (lcd_e)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_POR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        restart    = 1'b0;
        e_en       = 1'b0;
        case (state)
            ST_POR:   if (step_end && por_cnt == '0) state_next = ST_FSET;
            ST_FSET:  if (step_end) state_next = ST_DISP;
            ST_DISP:  if (step_end) state_next = ST_ENTRY;
            ST_ENTRY: if (step_end) state_next = ST_CLEAR;
            ST_CLEAR: if (step_end) state_next = ST_ADDR;
            ST_ADDR:  if (step_end) state_next = ST_CHAR;
            ST_CHAR:  if (step_end && char_idx == LAST_IDX) state_next = ST_IDLE;
            ST_IDLE: begin
                // Timer parked so a repaint starts on a fresh step.
                restart = 1'b1;
                if (mode != disp_mode) state_next = ST_ADDR;
            end
            default:  state_next = ST_POR;
        endcase
        e_en = !(state_next inside {ST_POR, ST_IDLE});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            por_cnt   <= PW'(POR_STEPS - 1);
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
            char_idx  <= 4'd0;
            disp_mode <= MODE_WATCH;
            busy      <= 1'b1;
        end else begin
            busy <= (state != ST_IDLE);
            if (state == ST_POR && step_end) begin
                por_cnt <= por_cnt - PW'(1);
            end
            if (state_next != state) begin
                lcd_rs <= (state_next == ST_CHAR);
                if (state_next inside {ST_FSET, ST_DISP, ST_ENTRY, ST_CLEAR, ST_ADDR}) begin
                    lcd_data <= state_cmd(state_next);
                end
                if (state_next == ST_ADDR) begin
                    disp_mode <= mode;
                end
            end
            // Lookup output settles during tick 0, so it is captured at the end of it.
            if (state == ST_CHAR) begin
                if (step_start) lcd_data <= char_data;
                if (step_end)   char_idx <= char_idx + 4'd1;
            end
        end
    end

    assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Randomised bench for lcd_sequencer: a pass-level model predicts every enable
// pulse (rs, data, disp_mode) and the busy flag, and a bus monitor checks strobe timing.
module tb_lcd_sequencer;
    import lcd_pkg::*;

    localparam int S           = 8;
    localparam int POR         = 2;
    localparam int INIT_ADDR_K = (POR + 4) * S - 1;
    localparam int INIT_IDLE_K = (POR + 21) * S;
    localparam int PASS        = 17 * S;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [7:0] char_data;
    logic [1:0] disp_mode;
    logic [3:0] char_idx;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic       busy;

    always #5 clk = ~clk;

    lcd_sequencer #(
        .STEP_CYCLES(S),
        .POR_STEPS  (POR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .char_data(char_data),
        .disp_mode(disp_mode),
        .char_idx (char_idx),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_data (lcd_data),
        .busy     (busy)
    );

    function automatic logic [7:0] text_lookup(input logic [1:0] m, input logic [3:0] i);
        string s;
        case (m)
            MODE_WATCH:     s = "MODE1: WATCH    ";
            MODE_ALARM:     s = "MODE2: ALARM    ";
            MODE_STOPWATCH: s = "MODE3: STOPWATCH";
            default:        return 8'h20;
        endcase
        return s[i];
    endfunction

    assign char_data = text_lookup(disp_mode, char_idx);

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic [1:0] dm;
        bit         chk_dm;
    } wr_t;

    wr_t        exp_q[$];
    int         tests  = 0;
    int         failed = 0;
    int         k;
    int         idle_from;
    bit         idle_prev;
    logic [1:0] shown;
    logic       prev_e;
    logic       prev_rs;
    logic [7:0] prev_data;
    logic       cap_rs;
    logic [7:0] cap_data;
    int         width;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_pass(input logic [1:0] m);
        exp_q.push_back('{1'b0, CMD_LINE1, m, 1'b1});
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back('{1'b1, text_lookup(m, 4'(i)), m, 1'b1});
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back('{1'b0, CMD_FSET,    2'b00, 1'b0});
        exp_q.push_back('{1'b0, CMD_DISP_ON, 2'b00, 1'b0});
        exp_q.push_back('{1'b0, CMD_ENTRY,   2'b00, 1'b0});
        exp_q.push_back('{1'b0, CMD_CLEAR,   2'b00, 1'b0});
        k         = 0;
        idle_from = INIT_IDLE_K;
        idle_prev = 1'b0;
        shown     = MODE_WATCH;
        prev_e    = 1'b0;
        prev_rs   = 1'b0;
        prev_data = 8'h00;
        width     = 0;
    endtask

    task automatic apply_reset(input logic [1:0] m);
        @(negedge clk);
        rst  = 1'b1;
        mode = m;
        #1;
        check("rst_e",    32'(lcd_e),     32'(0));
        check("rst_rs",   32'(lcd_rs),    32'(0));
        check("rst_rw",   32'(lcd_rw),    32'(0));
        check("rst_data", 32'(lcd_data),  32'(0));
        check("rst_idx",  32'(char_idx),  32'(0));
        check("rst_dm",   32'(disp_mode), 32'(0));
        check("rst_busy", 32'(busy),      32'(1));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cycle(input logic [1:0] m);
        wr_t w;
        bit  idle_now;
        @(negedge clk);
        mode = m;
        k++;
        idle_now = (k >= idle_from);
        check("busy", 32'(busy), 32'(!idle_prev));
        if (k == INIT_ADDR_K) begin
            shown = m;
            push_pass(m);
        end
        if (idle_now) begin
            check("idle_idx", 32'(char_idx),  32'(0));
            check("idle_rs",  32'(lcd_rs),    32'(0));
            check("idle_dm",  32'(disp_mode), 32'(shown));
            if (m != shown) begin
                shown     = m;
                idle_from = k + 1 + PASS;
                push_pass(m);
            end
        end
        idle_prev = idle_now;

        if (lcd_e && !prev_e) begin
            check("pre_rise_rs",   32'(lcd_rs),   32'(prev_rs));
            check("pre_rise_data", 32'(lcd_data), 32'(prev_data));
            check("pulse_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("rs",   32'(lcd_rs),   32'(w.rs));
                check("data", 32'(lcd_data), 32'(w.data));
                if (w.chk_dm) check("pulse_dm", 32'(disp_mode), 32'(w.dm));
            end
            cap_rs   = lcd_rs;
            cap_data = lcd_data;
            width    = 1;
        end else if (lcd_e) begin
            width++;
            check("hold_rs",   32'(lcd_rs),   32'(cap_rs));
            check("hold_data", 32'(lcd_data), 32'(cap_data));
        end else if (prev_e) begin
            check("e_width",        32'(width),    32'(S / 2));
            check("post_fall_rs",   32'(lcd_rs),   32'(cap_rs));
            check("post_fall_data", 32'(lcd_data), 32'(cap_data));
        end
        prev_e    = lcd_e;
        prev_rs   = lcd_rs;
        prev_data = lcd_data;
    endtask

    initial begin
        logic [1:0] m;

        // Power-on init and WATCH banner
        apply_reset(2'b00);
        repeat (200) cycle(2'b00);
        check("init_drained", 32'(exp_q.size()), 32'(0));

        // Repaint to ALARM, then reset part-way through a STOPWATCH repaint
        repeat (160) cycle(2'b01);
        check("alarm_drained", 32'(exp_q.size()), 32'(0));
        repeat (8 + 8 * 5 + 3) cycle(2'b10);
        apply_reset(2'b00);

        // Two mode changes during CHAR index 5 of the first pass: one repaint, ALARM
        for (int c = 1; c <= 340; c++) begin
            cycle(c < 97 ? 2'b00 : (c < 100 ? 2'b10 : 2'b01));
        end
        check("double_change_drained", 32'(exp_q.size()), 32'(0));
        check("double_change_dm", 32'(disp_mode), 32'(MODE_ALARM));

        // Unused mode code paints blanks
        repeat (160) cycle(2'b11);
        check("blank_drained", 32'(exp_q.size()), 32'(0));

        // Random mode traffic
        m = 2'b11;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) m = 2'($urandom_range(0, 3));
            cycle(m);
        end
        repeat (200) cycle(m);
        check("random_drained", 32'(exp_q.size()), 32'(0));
        check("final_busy", 32'(busy), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
